// File: rtl/dcache_line_memory.sv
// rtl/dcache_line_memory.sv - fixed-latency 256-bit line memory behind the data cache
// One request in flight; the write commits, or the read data registers, on the edge entering ACK.
module dcache_line_memory #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned IDX_W   = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               we_q, we_d;
  logic [255:0]       wdata_q, wdata_d;
  logic [255:0]       rdata_q, rdata_d;
  logic               commit;

  logic [255:0]       mem_q [DEPTH];

  // Offset bits and aliasing upper bits play no part in line selection.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  assign commit = (state_q == WAIT) && (cnt_q == 8'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          idx_d   = addr_i[IDX_W+4:5];
          we_d    = write_i;
          wdata_d = data_i;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (commit) begin
          state_d = ACK;
          if (!we_q) begin
            rdata_d = mem_q[idx_q];
          end
        end
      end
      ACK: begin
        // enable_i is deliberately not sampled here; the cache sees one idle cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; a reset mid-request leaves state_q in IDLE so nothing commits.
  always_ff @(posedge clk_i) begin
    if (commit && we_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ack_o  = (state_q == ACK);
  assign busy_o = (state_q != IDLE);
  assign data_o = rdata_q;

endmodule
